// File: rtl/line_queue_scheduler.sv
// Work-queue controller for the nonogram line solver: deduplicated circular queue
// of line indices, one line in flight, crossing lines re-enqueued on change.
module line_queue_scheduler #(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int N     = ROWS + COLS,
   parameter int IDX_W = $clog2(N),
   parameter int MAXL  = (ROWS > COLS) ? ROWS : COLS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   output logic             dispatch_valid_o,
   output logic [IDX_W-1:0] dispatch_line_o,
   input  logic             dispatch_ready_i,
   input  logic             result_valid_i,
   output logic             result_ready_o,
   input  logic             result_contradict_i,
   input  logic [MAXL-1:0]  result_changed_i,
   output logic             busy_o,
   output logic             solved_o,
   output logic             contradiction_o,
   output logic [IDX_W:0]   queue_count_o
);

   localparam int KW = (MAXL > 1) ? $clog2(MAXL) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_DISPATCH  = 3'd2;
   localparam logic [2:0] S_WAIT      = 3'd3;
   localparam logic [2:0] S_REQUEUE   = 3'd4;
   localparam logic [2:0] S_DONE_OK   = 3'd5;
   localparam logic [2:0] S_DONE_FAIL = 3'd6;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] ROWS_IDX = IDX_W'(ROWS);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);
   localparam logic [KW-1:0]    K_ONE    = KW'(1);
   localparam logic [KW-1:0]    ROW_LAST = KW'(COLS - 1);
   localparam logic [KW-1:0]    COL_LAST = KW'(ROWS - 1);

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic [N-1:0]     inq_q, inq_d;
   logic [IDX_W-1:0] load_idx_q, load_idx_d;
   logic [IDX_W-1:0] cur_line_q, cur_line_d;
   logic [MAXL-1:0]  changed_q, changed_d;
   logic [KW-1:0]    k_q, k_d;
   logic             solved_q, solved_d;
   logic             contra_q, contra_d;
   logic [IDX_W-1:0] q_mem_q [N];

   logic             push_en, pop_en, mem_we, cur_is_row;
   logic [IDX_W-1:0] push_line, head_line;
   logic [KW-1:0]    k_last;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + IDX_ONE;
   endfunction

   assign head_line  = q_mem_q[head_q];
   assign cur_is_row = (cur_line_q < ROWS_IDX);
   assign k_last     = cur_is_row ? ROW_LAST : COL_LAST;

   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      inq_d      = inq_q;
      load_idx_d = load_idx_q;
      cur_line_d = cur_line_q;
      changed_d  = changed_q;
      k_d        = k_q;
      solved_d   = solved_q;
      contra_d   = contra_q;
      push_en    = 1'b0;
      push_line  = '0;
      pop_en     = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
            if (start_i) begin
               solved_d   = 1'b0;
               contra_d   = 1'b0;
               head_d     = '0;
               tail_d     = '0;
               count_d    = '0;
               inq_d      = '0;
               load_idx_d = '0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            push_en    = 1'b1;
            push_line  = load_idx_q;
            load_idx_d = load_idx_q + IDX_ONE;
            if (load_idx_q == LAST_IDX) state_d = S_DISPATCH;
         end
         S_DISPATCH: begin
            if (count_q == '0) begin
               solved_d = 1'b1;
               state_d  = S_DONE_OK;
            end else if (dispatch_ready_i) begin
               pop_en     = 1'b1;
               cur_line_d = head_line;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (result_valid_i) begin
               if (result_contradict_i) begin
                  contra_d = 1'b1;
                  state_d  = S_DONE_FAIL;
               end else begin
                  changed_d = result_changed_i;
                  k_d       = '0;
                  state_d   = S_REQUEUE;
               end
            end
         end
         S_REQUEUE: begin
            // A row's changed cell k lies on column ROWS+k; a column's on row k.
            push_en   = changed_q[k_q];
            push_line = cur_is_row ? (ROWS_IDX + IDX_W'(k_q)) : IDX_W'(k_q);
            if (k_q == k_last) state_d = S_DISPATCH;
            else               k_d     = k_q + K_ONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push_en && !inq_q[push_line]) begin
         mem_we           = 1'b1;
         tail_d           = wrap_inc(tail_q);
         count_d          = count_q + CNT_ONE;
         inq_d[push_line] = 1'b1;
      end
      if (pop_en) begin
         head_d           = wrap_inc(head_q);
         count_d          = count_q - CNT_ONE;
         inq_d[head_line] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inq_q      <= '0;
         load_idx_q <= '0;
         cur_line_q <= '0;
         changed_q  <= '0;
         k_q        <= '0;
         solved_q   <= 1'b0;
         contra_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inq_q      <= inq_d;
         load_idx_q <= load_idx_d;
         cur_line_q <= cur_line_d;
         changed_q  <= changed_d;
         k_q        <= k_d;
         solved_q   <= solved_d;
         contra_q   <= contra_d;
      end
   end

   // Queue storage needs no reset: entries are only read between head and tail.
   always_ff @(posedge clk_i) begin
      if (mem_we) q_mem_q[tail_q] <= push_line;
   end

   assign dispatch_valid_o = (state_q == S_DISPATCH) && (count_q != '0);
   assign dispatch_line_o  = dispatch_valid_o ? head_line : '0;
   assign result_ready_o   = (state_q == S_WAIT);
   assign busy_o           = (state_q == S_LOAD) || (state_q == S_DISPATCH) ||
                             (state_q == S_WAIT) || (state_q == S_REQUEUE);
   assign solved_o         = solved_q;
   assign contradiction_o  = contra_q;
   assign queue_count_o    = count_q;

endmodule
